// File: rtl/piano_pkg.sv
// Shared pitch definitions for the piano: note and octave codes, the
// mid-octave half-period table and the tone generator state encoding.
package piano_pkg;

  localparam int HALF_W = 19;

  typedef enum logic [3:0] {
    NOTE_REST = 4'd0,
    NOTE_DO   = 4'd1,
    NOTE_RE   = 4'd2,
    NOTE_MI   = 4'd3,
    NOTE_FA   = 4'd4,
    NOTE_SO   = 4'd5,
    NOTE_LA   = 4'd6,
    NOTE_SI   = 4'd7
  } note_t;

  typedef enum logic [1:0] {
    OCT_MID_ALT = 2'b00,
    OCT_LOW     = 2'b01,
    OCT_MID     = 2'b10,
    OCT_HIGH    = 2'b11
  } octave_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_GAP  = 2'd2
  } tone_state_t;

  // Mid-octave half periods in 100 MHz clocks; codes 8..15 fall to rest.
  function automatic logic [HALF_W-1:0] mid_half(input logic [3:0] note);
    case (note)
      NOTE_DO: mid_half = 19'd191110;
      NOTE_RE: mid_half = 19'd170265;
      NOTE_MI: mid_half = 19'd151685;
      NOTE_FA: mid_half = 19'd143172;
      NOTE_SO: mid_half = 19'd127551;
      NOTE_LA: mid_half = 19'd113636;
      NOTE_SI: mid_half = 19'd101239;
      default: mid_half = '0;
    endcase
  endfunction

endpackage

// File: rtl/tone_period_lut.sv
// Combinational (note, octave) -> half period in clocks; rest gives 0.
// Shared with the pitch checkers, so it stays free of any state.
module tone_period_lut
  import piano_pkg::*;
(
  input  logic [3:0]        note,
  input  logic [1:0]        octave,
  output logic [HALF_W-1:0] half_period
);

  logic [HALF_W-1:0] base;

  always_comb begin
    base = mid_half(note);
    case (octave)
      OCT_LOW:  half_period = base << 1;
      OCT_HIGH: half_period = base >> 1;
      default:  half_period = base;
    endcase
  end

endmodule

// File: rtl/tone_generator.sv
// Buzzer square-wave generator; pitch changes only at full-cycle boundaries.
// state | meaning: IDLE silent, amp off | TONE square wave out | GAP silent, amp on
module tone_generator #(
  parameter int GAP_CYCLES  = 1_000_000,
  parameter int HALF_W      = 19,
  parameter int PITCH_SHIFT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] note,
  input  logic [1:0] octave,
  output logic       speaker,
  output logic       audio_sd,
  output logic       note_active
);
  import piano_pkg::*;

  localparam int LUT_W = piano_pkg::HALF_W;

  logic [3:0]        note_q;
  logic [1:0]        oct_q;
  logic [LUT_W-1:0]  lut_half;
  logic [HALF_W-1:0] target;
  logic [HALF_W-1:0] cur_half, cur_half_d;
  logic [HALF_W-1:0] cnt, cnt_d;
  logic [31:0]       gap_cnt, gap_cnt_d;
  logic              spk_q, spk_d;
  logic              half_done, gap_done;
  tone_state_t       state, state_d;

  tone_period_lut u_lut (
    .note        (note_q),
    .octave      (oct_q),
    .half_period (lut_half)
  );

  // PITCH_SHIFT > 0 shortens every period by a power of two for fast builds.
  assign target    = HALF_W'(lut_half >> PITCH_SHIFT);
  assign half_done = (cnt == cur_half - 1'b1);
  assign gap_done  = (gap_cnt == 32'(GAP_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      note_q   <= '0;
      oct_q    <= '0;
      state    <= ST_IDLE;
      cur_half <= '0;
      cnt      <= '0;
      gap_cnt  <= '0;
      spk_q    <= 1'b0;
    end else begin
      note_q   <= note;
      oct_q    <= octave;
      state    <= state_d;
      cur_half <= cur_half_d;
      cnt      <= cnt_d;
      gap_cnt  <= gap_cnt_d;
      spk_q    <= spk_d;
    end
  end

  always_comb begin
    state_d    = state;
    cur_half_d = cur_half;
    cnt_d      = cnt;
    gap_cnt_d  = gap_cnt;
    spk_d      = spk_q;
    case (state)
      ST_IDLE: begin
        if (target != '0) begin
          cur_half_d = target;
          cnt_d      = '0;
          state_d    = ST_TONE;
        end
      end
      ST_TONE: begin
        cnt_d = cnt + 1'b1;
        if (half_done) begin
          cnt_d = '0;
          spk_d = ~spk_q;
          // Falling toggle closes a full cycle: the only point pitch may change.
          if (spk_q) begin
            if (target == '0) begin
              state_d = ST_IDLE;
            end else if (target != cur_half) begin
              if (GAP_CYCLES > 0) begin
                state_d   = ST_GAP;
                gap_cnt_d = '0;
              end else begin
                cur_half_d = target;
              end
            end
          end
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt + 32'd1;
        if (gap_done) begin
          if (target == '0) begin
            state_d = ST_IDLE;
          end else begin
            cur_half_d = target;
            cnt_d      = '0;
            state_d    = ST_TONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign speaker     = spk_q;
  assign audio_sd    = (state != ST_IDLE);
  assign note_active = (state == ST_TONE);

endmodule
